// File: rtl/adder_pkg.sv
// Shared types and default sizing for the slice-sequenced adder.
package adder_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into the MSB
// so the caller can derive signed overflow.
module adder_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Add/subtract unit that time-shares one narrow adder slice over DATA_W/SLICE_W
// cycles, LSB slice first, with valid/ready handshakes on both sides.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SLICE_W = DEF_SLICE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  input  logic              i_sub,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_carry,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam int unsigned NSLICE = DATA_W / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t               state_q;
  state_t               state_next;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;
  logic                 carry_q;
  logic [IDX_W-1:0]     idx_q;

  logic                 accept_c;
  logic                 step_c;
  logic                 last_c;
  logic [SLICE_W-1:0]   sl_a;
  logic [SLICE_W-1:0]   sl_b;
  logic [SLICE_W-1:0]   sl_sum;
  logic                 sl_cout;
  logic                 sl_cmsb;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next = state_q;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          accept_c   = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sl_a = a_q[32'(idx_q) * SLICE_W +: SLICE_W];
    sl_b = b_q[32'(idx_q) * SLICE_W +: SLICE_W];
  end

  adder_slice #(.W(SLICE_W)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  // Operand capture, slice accumulation and registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      o_data     <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_ready <= (state_next == IDLE);
      o_valid <= (state_next == DONE);
      o_busy  <= (state_next != IDLE);
      if (accept_c) begin
        a_q     <= i_data_a;
        b_q     <= i_data_b ^ {DATA_W{i_sub}};
        carry_q <= i_sub;
        idx_q   <= '0;
      end
      if (step_c) begin
        o_data[32'(idx_q) * SLICE_W +: SLICE_W] <= sl_sum;
        carry_q <= sl_cout;
        if (last_c) begin
          o_carry    <= sl_cout;
          o_overflow <= sl_cmsb ^ sl_cout;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed and random bench for adder_seq_ctrl at default sizing.
module tb_adder_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_carry;
  logic        o_overflow;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  adder_seq_ctrl #(.DATA_W(32), .SLICE_W(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_a   (i_data_a),
    .i_data_b   (i_data_b),
    .i_sub      (i_sub),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One full transaction: accept, latency, result, optional stall, handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] exp_d, input logic exp_c, input logic exp_v,
                        input int stall, input bit toggle);
    int lat;
    lat = 0;
    while (!o_ready && lat < 50) begin
      tick();
      lat++;
    end
    check_eq("ready_idle", 64'(o_ready), 64'd1);
    i_valid  = 1'b1;
    i_data_a = a;
    i_data_b = b;
    i_sub    = sub;
    tick();
    i_valid = 1'b0;
    check_eq("busy_calc", 64'({o_busy, o_ready}), 64'b10);
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("latency", 64'(lat), 64'd4);
    check_eq("data", 64'(o_data), 64'(exp_d));
    check_eq("carry", 64'(o_carry), 64'(exp_c));
    check_eq("overflow", 64'(o_overflow), 64'(exp_v));
    for (int s = 0; s < stall; s++) begin
      i_ready = 1'b0;
      if (toggle) begin
        i_valid  = ~i_valid;
        i_data_a = $urandom;
        i_data_b = $urandom;
        i_sub    = ~i_sub;
      end
      tick();
      check_eq("stall_hold", 64'({o_valid, o_ready, o_carry, o_overflow, o_data}),
               64'({1'b1, 1'b0, exp_c, exp_v, exp_d}));
    end
    i_ready = 1'b1;
    i_valid = toggle;
    tick();
    i_ready = 1'b0;
    check_eq("post_xfer_idle", 64'({o_valid, o_ready, o_busy}), 64'b010);
    i_valid = 1'b0;
    check_eq("retain_idle", 64'(o_data), 64'(exp_d));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] bb;
    logic        rs;
    logic [32:0] sum33;
    logic        rv;

    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data_a = '0;
    i_data_b = '0;
    i_sub    = 1'b0;
    tick();
    tick();
    check_eq("reset_state",
             64'({o_ready, o_valid, o_busy, o_carry, o_overflow, o_data}),
             64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
    i_rst = 1'b0;
    tick();

    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1'b0);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 1'b0);
    // DONE stall with i_valid/operands toggling; i_valid high on the transfer edge
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 3, 1'b1);

    // Reset mid-CALC at idx 2, with i_valid/i_ready also high
    i_valid  = 1'b1;
    i_data_a = 32'hDEAD_BEEF;
    i_data_b = 32'h0101_0101;
    i_sub    = 1'b0;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    tick();
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    check_eq("mid_calc_reset",
             64'({o_ready, o_valid, o_busy, o_carry, o_overflow, o_data}),
             64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
    tick();
    check_eq("reset_stays_idle", 64'({o_ready, o_busy}), 64'b10);
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'(($urandom_range(0, 1)));
      if (n % 50 == 0) ra = 32'h8000_0000;
      if (n % 50 == 1) rb = 32'h7FFF_FFFF;
      bb    = rs ? ~rb : rb;
      sum33 = {1'b0, ra} + {1'b0, bb} + 33'(rs);
      rv    = (ra[31] == bb[31]) && (sum33[31] != ra[31]);
      run_op(ra, rb, rs, sum33[31:0], sum33[32], rv, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand and result width.
REQ-002 The block SHALL have parameter SLICE_W, default 8, width of the shared adder slice; DATA_W % SLICE_W == 0.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  requester presents an operation.
REQ-006 o_ready  output  1  block accepts an operation this cycle.
REQ-007 i_data_a  input  DATA_W  operand A.
REQ-008 i_data_b  input  DATA_W  operand B.
REQ-009 i_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 o_valid  output  1  result available.
REQ-011 i_ready  input  1  consumer takes the result.
REQ-012 o_data  output  DATA_W  sum/difference.
REQ-013 o_carry  output  1  final carry out (for subtract: 1 = no borrow).
REQ-014 o_overflow  output  1  signed overflow flag.
REQ-015 o_busy  output  1  high in CALC or DONE.

Function
REQ-016 The block SHALL sequence one shared SLICE_W-bit adder slice over NSLICE = DATA_W/SLICE_W cycles, LSB slice first.
REQ-017 FSM states SHALL be IDLE, CALC, DONE.
REQ-018 In IDLE, o_ready = 1, o_valid = 0; i_valid=1 SHALL latch A, B XOR {DATA_W{i_sub}}, carry register = i_sub, slice index = 0, and go to CALC.
REQ-019 o_ready SHALL be 0 in CALC and DONE; i_valid and operand changes there SHALL be ignored.
REQ-020 In CALC, each cycle SHALL add slice[idx] of A and B with the carry register, write the sum into result slice idx, update the carry register, and increment idx.
REQ-021 When idx == NSLICE-1 in CALC, the next state SHALL be DONE; idx SHALL NOT wrap past NSLICE-1.
REQ-022 Latency: o_valid SHALL rise exactly NSLICE cycles after the accepting edge (4 cycles at defaults).
REQ-023 o_overflow SHALL equal the carry into the MSB XOR the carry out of the MSB, captured on the last slice.
REQ-024 In DONE, o_valid = 1 and o_data/o_carry/o_overflow SHALL hold stable until i_valid... until i_ready = 1; o_valid&&i_ready SHALL return the FSM to IDLE on that edge.
REQ-025 No operation SHALL be accepted in the cycle o_valid&&i_ready completes; acceptance requires IDLE.
REQ-026 o_data/o_carry/o_overflow SHALL retain the last result in IDLE until the next result is written.

Reset
REQ-027 i_rst = 1 SHALL force IDLE on the next edge from any state, including mid-CALC, discarding the operation.
REQ-028 Reset values: o_data = 0, o_carry = 0, o_overflow = 0, o_valid = 0, o_busy = 0, o_ready = 1 (IDLE), idx = 0.
REQ-029 i_rst SHALL take priority over i_valid and i_ready in the same cycle.

Structure
REQ-030 A shared package adder_pkg SHALL hold the state enum (IDLE, CALC, DONE) and default DATA_W/SLICE_W constants.
REQ-031 The slice SHALL be a separate combinational sub-module adder_slice (SLICE_W ripple of full adders, outputs sum, carry out, carry into MSB).
REQ-032 Only one adder_slice instance SHALL exist; all slices time-share it.

Verification
REQ-033 A=0x0000_0001, B=0xFFFF_FFFF, add -> o_data=0x0000_0000, o_carry=1, o_overflow=0, o_valid 4 cycles after accept.
REQ-034 A=0x7FFF_FFFF, B=0x0000_0001, add -> o_data=0x8000_0000, o_carry=0, o_overflow=1.
REQ-035 A=5, B=7, sub -> o_data=0xFFFF_FFFE, o_carry=0, o_overflow=0; A=7, B=5, sub -> 0x0000_0002, o_carry=1.
REQ-036 Hold i_ready=0 for 3 cycles in DONE while toggling i_valid/operands -> outputs stable, o_ready=0, one transfer on i_ready=1, IDLE next cycle.
REQ-037 Assert i_rst for one cycle at CALC idx=2 -> IDLE next edge, all outputs at reset values, next operation correct.
REQ-038 1000 random add/sub operations with random i_ready stalls -> every result matches a 33-bit reference model, including carry and overflow.
